// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver: digit values and
// controls in, multiplexed anode/segment drive out.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  ce;
  logic [4*DIGITS-1:0]   hex_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  disp_off;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_start;

  modport master (
    output ce, hex_in, dp_in, disp_off,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  ce, hex_in, dp_in, disp_off,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with per-slot blanking and
// once-per-frame input snapshot; all display outputs are registered.
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input logic           clk,
  input logic           rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   sh_hex;
  logic [DIGITS-1:0]        sh_dp;
  logic [DIGITS-1:0]        an_sel;
  logic                     slot_end, wrap, in_blank;

  logic [DIGITS-1:0]        an_q;
  logic [6:0]               seg_q;
  logic                     dp_q, fs_q;

  assign slot_end = bus.ce && (cnt == CW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(DIGITS - 1));

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  // Per-digit shadow capture and one-hot anode select.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sh_hex[k] <= 4'h0;
          sh_dp[k]  <= 1'b0;
        end else if (wrap) begin
          sh_hex[k] <= bus.hex_in[4*k +: 4];
          sh_dp[k]  <= bus.dp_in[k];
        end
      end
      assign an_sel[k] = ~(idx == IW'(k));
    end
  endgenerate

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      if (bus.ce) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      fs_q <= wrap;
      // Outputs follow the pre-edge scan state, so a frozen scan holds them.
      if (bus.disp_off || in_blank) begin
        an_q  <= '1;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= an_sel;
        seg_q <= decode(sh_hex[idx]);
        dp_q  <= ~sh_dp[idx];
      end
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: constant vector table, hand corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_seg7_scan_driver;
  localparam int D = 4, S = 8, B = 2;
  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();
  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [15:0]     hex;
    logic [3:0]      dpv;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } rec_t;
  rec_t tab [6];

  int checks = 0, errors = 0;
  int ecnt;                // enabled clock edges since reset
  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fs;

  task automatic chk(input string name, input logic [3:0] an, input logic [6:0] seg,
                     input logic dp, input logic fs);
    checks++;
    if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {an, seg, dp, fs}) begin
      errors++;
      $display("FAIL %s t=%0t: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
               name, $time, bus.an, bus.seg, bus.dp, bus.frame_start, an, seg, dp, fs);
    end
  endtask

  // One clock: predict from the model, advance the model, then compare.
  task automatic cyc(input bit do_chk);
    int pos, c, k;
    pos = ecnt % (S*D);
    c   = pos % S;
    k   = pos / S;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (!bus.disp_off && c >= B) begin
      e_an[k] = 1'b0;
      e_seg   = DEC[m_hex[4*k +: 4]];
      e_dp    = ~m_dp[k];
    end
    e_fs = bus.ce && (pos == S*D - 1);
    if (bus.ce) begin
      ecnt++;
      if (e_fs) begin m_hex = bus.hex_in; m_dp = bus.dp_in; end
    end
    @(posedge clk); #1;
    if (do_chk) chk("model", e_an, e_seg, e_dp, e_fs);
  endtask

  task automatic model_reset();
    ecnt = 0; m_hex = '0; m_dp = '0;
  endtask

  task automatic reset_pulse(input int hold);
    rst = 1'b0; #1;
    model_reset();
    chk("reset_async", 4'hF, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < hold; i++) begin
      bus.hex_in = 16'($urandom); bus.dp_in = 4'($urandom); bus.ce = 1'($urandom);
      @(posedge clk); #1;
      chk("reset_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    end
    rst = 1'b1;
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 64 && (ecnt % (S*D)) != pos; i++) cyc(1);
    if ((ecnt % (S*D)) != pos) begin
      errors++; checks++;
      $display("FAIL run_to: reached pos %0d, want %0d", ecnt % (S*D), pos);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] a;
    bit seen;
    tab[0] = '{hex:16'h12A4, dpv:4'b0010, seg:{7'h79, 7'h24, 7'h08, 7'h19}, dpn:4'b1101};
    tab[1] = '{hex:16'hFFFF, dpv:4'b1111, seg:{7'h0E, 7'h0E, 7'h0E, 7'h0E}, dpn:4'b0000};
    tab[2] = '{hex:16'h0F80, dpv:4'b0101, seg:{7'h40, 7'h0E, 7'h00, 7'h40}, dpn:4'b1010};
    tab[3] = '{hex:16'hCDEB, dpv:4'b1000, seg:{7'h46, 7'h21, 7'h06, 7'h03}, dpn:4'b0111};
    tab[4] = '{hex:16'h9765, dpv:4'b0000, seg:{7'h10, 7'h78, 7'h02, 7'h12}, dpn:4'b1111};
    tab[5] = '{hex:16'h3000, dpv:4'b0001, seg:{7'h30, 7'h40, 7'h40, 7'h40}, dpn:4'b1110};

    bus.ce = 1'b0; bus.disp_off = 1'b0; bus.hex_in = '0; bus.dp_in = '0;
    model_reset();
    rst = 1'b1; #2;
    reset_pulse(3);

    // Release: two blank cycles, then digit 0 shows '0'.
    bus.ce = 1'b1; bus.hex_in = 16'h5555; bus.dp_in = 4'hF;
    for (int j = 1; j <= 8; j++) begin
      cyc(1);
      if (j <= 2) chk("rel_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
      else        chk("rel_digit0", 4'b1110, 7'h40, 1'b1, 1'b0);
    end

    // Vector table; the next value is applied mid-slot 1 and must not tear.
    bus.hex_in = tab[0].hex; bus.dp_in = tab[0].dpv;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      cyc(1);
      seen = bus.frame_start;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL fs_timeout: frame_start=0 after 64 cycles, want 1");
    end
    for (int i = 0; i < 6; i++) begin
      for (int j = 1; j <= S*D; j++) begin
        int k;
        if (j == 12 && i < 5) begin bus.hex_in = tab[i+1].hex; bus.dp_in = tab[i+1].dpv; end
        cyc(1);
        k = (j - 1) / S;
        a = 4'hF; a[k] = 1'b0;
        if ((j - 1) % S < B) chk("tab_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
        else                 chk("tab_show", a, tab[i].seg[k], tab[i].dpn[k], j == S*D);
      end
    end

    // ce freeze mid-SHOW of slot 2 (shadow holds 16'h3000, dp 0001).
    run_to(2*S + 4);
    bus.ce = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("freeze", 4'b1011, 7'h40, 1'b1, 1'b0);
    end
    bus.ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("resume", 4'b1011, 7'h40, 1'b1, 1'b0);
    end
    cyc(1);
    chk("resume_blank", 4'hF, 7'h7F, 1'b1, 1'b0);

    // disp_off for 5 cycles in slot 3; frame_start still lands on schedule.
    bus.disp_off = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("disp_off", 4'hF, 7'h7F, 1'b1, 1'b0);
    end
    bus.disp_off = 1'b0;
    cyc(1);
    chk("disp_on", 4'b0111, 7'h30, 1'b1, 1'b0);
    cyc(1);
    chk("disp_fs", 4'b0111, 7'h30, 1'b1, 1'b1);

    // Reset during slot 3 SHOW: shadow cleared, scan restarts.
    run_to(3*S + 4);
    reset_pulse(2);
    bus.ce = 1'b1; bus.hex_in = 16'h8888; bus.dp_in = 4'hF;
    for (int j = 1; j <= 8; j++) begin
      cyc(1);
      if (j <= 2) chk("rst_mid_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
      else        chk("rst_mid_digit0", 4'b1110, 7'h40, 1'b1, 1'b0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.ce       = ($urandom_range(0, 9) < 8);
      bus.disp_off = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.hex_in = 16'($urandom); bus.dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 499) == 0) reset_pulse(1);
      else cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed seven-segment display driver that sits directly downstream of the board-level input/logic stage and consumes its 4-bit-per-digit hex values and decimal-point flags. It time-multiplexes DIGITS common-anode digits, inserts a blanking gap at the start of every digit slot to suppress ghosting, and snapshots its inputs once per frame so a digit never shows a value that changes mid-scan. Control mirrors the existing display interface: clock-enable, display-off and hex/dp inputs.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8).
- SCAN_DIV, 1000: enabled clk cycles per digit slot (>= 2).
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV).

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  scan advance enable; 0 freezes the scan.
- hex_in  in  4*DIGITS  digit k value = hex_in[4k+3:4k].
- dp_in  in  DIGITS  dp_in[k]=1 lights decimal point of digit k.
- disp_off  in  1  1 blanks all outputs; scan keeps running.
- an  out  DIGITS  anode selects, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- State: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), shadow registers sh_hex/sh_dp.
- ce=1: cnt increments; at cnt=SCAN_DIV-1 cnt wraps to 0 and idx increments, wrapping DIGITS-1 -> 0. ce=0: cnt, idx, shadow hold.
- Frame wrap event = ce=1 & cnt=SCAN_DIV-1 & idx=DIGITS-1. On that edge sh_hex<=hex_in, sh_dp<=dp_in; frame_start is 1 for exactly the following cycle.
- Slot phase: BLANK when cnt<BLANK_CYC, SHOW otherwise.
  - BLANK: an all 1, seg=7'h7F, dp=1.
  - SHOW: an[idx]=0, others 1; seg=decode(sh_hex digit idx); dp=~sh_dp[idx].
- disp_off=1 overrides phase: an all 1, seg=7'h7F, dp=1.
- Decode (hex -> seg): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
- Never more than one anode low in any cycle.

## Timing
- an, seg, dp, frame_start are registered: value in cycle t reflects cnt, idx, shadow and disp_off of cycle t-1.
- Reset (rst=0, immediate): cnt=0, idx=0, sh_hex=0, sh_dp=0, an=all 1, seg=7'h7F, dp=1, frame_start=0.
- After rst release with ce=1: first BLANK_CYC cycles blank, then digit 0 shows '0' (shadow=0) until the first frame wrap; first frame_start arrives DIGITS*SCAN_DIV cycles after release.
- hex_in/dp_in changes mid-frame are invisible until the next frame wrap.
- Reset mid-slot aborts the scan; outputs blank in the same cycle as rst falls.
- ce low during SHOW keeps that digit lit indefinitely; ce low during BLANK keeps outputs blank.
- BLANK_CYC=0: no blanking, slot boundary switches anodes directly.

## Test plan
Parameters DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset: hold rst=0 with random inputs -> an=4'hF, seg=7'h7F, dp=1, frame_start=0; release, ce=1 -> cycles 1-2 blank, cycles 3-8 an=4'b1110, seg=7'h40.
- Capture/decode: hex_in=16'h12A4, dp_in=4'b0010, ce=1 for 2 frames -> after frame_start, slot 0 an=1110 seg=7'h19 dp=1; slot 1 an=1101 seg=7'h08 dp=0; slot 2 seg=7'h24; slot 3 seg=7'h79; each slot 2 blank cycles then 6 lit.
- Tearing: change hex_in to 16'hFFFF during slot 1 -> slots 1-3 still show A,2,1; after next frame_start all slots seg=7'h0E.
- ce freeze: drop ce for 20 cycles mid-SHOW of slot 2 -> an=1011 and seg constant for 20 cycles, no frame_start; resume completes slot with remaining count.
- disp_off: assert 5 cycles mid-slot -> outputs blank one cycle later for 5 cycles; frame_start timing unchanged vs. reference count.
- Reset mid-operation: assert rst during slot 3 SHOW -> outputs blank immediately, shadow cleared, scan restarts at idx 0, cnt 0.
